// File: rtl/uart_tx_arbiter.sv
// Locks one requester onto a shared uart_tx write port until end-of-message, burst limit or stall timeout.
// Arbitration takes 1 cycle in IDLE; while LOCKED the owner's req/data/gnt pass straight through.
module uart_tx_arbiter #(
    parameter int         N_REQ        = 4,
    parameter int         BYTE_WIDTH   = 1,
    parameter logic [7:0] EOM_CHAR     = 8'h0A,
    parameter int         IDLE_TIMEOUT = 1024,
    parameter int         MAX_BURST    = 256,
    localparam int        OW           = $clog2(N_REQ),
    localparam int        DW           = BYTE_WIDTH * 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    output logic [N_REQ-1:0]    gnt,
    input  logic [N_REQ*DW-1:0] data,
    output logic                o_wreq,
    input  logic                i_wgnt,
    output logic [DW-1:0]       o_wdata,
    output logic                o_busy,
    output logic [OW-1:0]       o_owner
);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t        r_state, w_state_nxt;
    logic [OW-1:0] r_owner, w_owner_nxt;
    logic [OW-1:0] r_last_owner, w_last_nxt;
    logic [31:0]   r_burst_cnt, w_burst_nxt;
    logic [31:0]   r_idle_cnt, w_idle_nxt;

    logic [OW-1:0] w_pick, w_idx;
    logic          w_any;
    logic [DW-1:0] w_owner_dat;
    logic          w_xfer;
    logic          w_release;
    logic [32:0]   w_burst_inc;

    assign w_owner_dat = data[r_owner*DW +: DW];
    assign w_burst_inc = {1'b0, r_burst_cnt} + 33'd1;

    // Round-robin search starting just after the previous owner, so it ranks last.
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        w_idx  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = OW'((int'(r_last_owner) + i) % N_REQ);
            if (!w_any && req[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last_owner;
        w_burst_nxt = r_burst_cnt;
        w_idle_nxt  = r_idle_cnt;
        gnt         = '0;
        o_wreq      = 1'b0;
        o_wdata     = '0;
        w_xfer      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_LOCKED;
                    w_owner_nxt = w_pick;
                    w_burst_nxt = '0;
                    w_idle_nxt  = '0;
                end
            end
            S_LOCKED: begin
                o_wreq       = req[r_owner];
                o_wdata      = w_owner_dat;
                gnt[r_owner] = i_wgnt;
                w_xfer       = o_wreq && i_wgnt;
                if (w_xfer) begin
                    w_burst_nxt = w_burst_inc[32] ? r_burst_cnt : w_burst_inc[31:0];
                    w_idle_nxt  = '0;
                    if (w_owner_dat[7:0] == EOM_CHAR)
                        w_release = 1'b1;
                    if (MAX_BURST > 0 && w_burst_inc == 33'(MAX_BURST))
                        w_release = 1'b1;
                end else begin
                    w_idle_nxt = (r_idle_cnt == '1) ? r_idle_cnt : r_idle_cnt + 32'd1;
                    if (r_idle_cnt == 32'(IDLE_TIMEOUT - 1))
                        w_release = 1'b1;
                end
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = r_owner;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Nothing may leak to uart_tx while reset is held, even mid-lock.
        if (rst) begin
            gnt     = '0;
            o_wreq  = 1'b0;
            o_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= '0;
            r_last_owner <= OW'(N_REQ - 1);
            r_burst_cnt  <= '0;
            r_idle_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_nxt;
            r_burst_cnt  <= w_burst_nxt;
            r_idle_cnt   <= w_idle_nxt;
        end
    end

    assign o_busy  = !rst && (r_state == S_LOCKED);
    assign o_owner = rst ? '0 : r_owner;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte-queue requesters, transfer log, hand-computed expectations.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [31:0] data;
    logic        o_wreq;
    logic        i_wgnt;
    logic [7:0]  o_wdata;
    logic        o_busy;
    logic [1:0]  o_owner;
    logic        ready;

    always #5 clk = ~clk;

    assign i_wgnt = o_wreq & ready;

    uart_tx_arbiter #(
        .N_REQ(4), .BYTE_WIDTH(1), .EOM_CHAR(8'h0A), .IDLE_TIMEOUT(8), .MAX_BURST(4)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .data(data),
        .o_wreq(o_wreq), .i_wgnt(i_wgnt), .o_wdata(o_wdata),
        .o_busy(o_busy), .o_owner(o_owner)
    );

    logic [7:0] msg [4][16];
    int         pos [4];
    int         len [4];
    logic [3:0] en;

    int         xo [64];
    logic [7:0] xb [64];
    int         xc [64];
    int         nx;
    int         eo [64];
    logic [7:0] eb [64];
    int         eg [64];
    int         ne;

    int cyc_n;
    int tests;
    int fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int i, input string s);
        for (int k = 0; k < s.len(); k++) msg[i][k] = s[k];
        len[i] = s.len();
        pos[i] = 0;
    endtask

    task automatic drive();
        data = '0;
        for (int i = 0; i < 4; i++) begin
            req[i] = en[i] && (pos[i] < len[i]);
            if (req[i]) data[i*8 +: 8] = msg[i][pos[i]];
        end
    endtask

    function automatic bit all_done();
        bit d = 1'b1;
        for (int i = 0; i < 4; i++) if (pos[i] < len[i]) d = 1'b0;
        return d;
    endfunction

    // Sample before the edge, pop granted words after it, then let inputs settle.
    task automatic tick();
        logic [3:0] g;
        #1;
        g = gnt;
        if (o_wreq && i_wgnt && nx < 64) begin
            xo[nx] = int'(o_owner);
            xb[nx] = o_wdata;
            xc[nx] = cyc_n;
            nx++;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        for (int i = 0; i < 4; i++) if (g[i]) pos[i]++;
        drive();
        #1;
    endtask

    task automatic run_until_done(input string tag, input int max_cyc);
        for (int k = 0; k < max_cyc && !all_done(); k++) tick();
        chk({tag, "_drained"}, 32'(all_done()), 32'd1);
    endtask

    task automatic clear_log();
        nx = 0;
        ne = 0;
    endtask

    task automatic exp_x(input int o, input logic [7:0] b, input int g);
        eo[ne] = o;
        eb[ne] = b;
        eg[ne] = g;
        ne++;
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_count"}, 32'(nx), 32'(ne));
        for (int k = 0; k < ne && k < nx; k++) begin
            chk($sformatf("%s_own%0d", tag, k), 32'(xo[k]), 32'(eo[k]));
            chk($sformatf("%s_byte%0d", tag, k), {24'd0, xb[k]}, {24'd0, eb[k]});
            if (k > 0) chk($sformatf("%s_gap%0d", tag, k), 32'(xc[k] - xc[k-1]), 32'(eg[k]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; fails = 0; cyc_n = 0; nx = 0; ne = 0;
        for (int i = 0; i < 4; i++) begin pos[i] = 0; len[i] = 0; end
        rst = 1'b1; ready = 1'b1; en = 4'b0000;
        drive();
        tick(); tick();
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_owner", 32'(o_owner), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_wreq", 32'(o_wreq), 32'd0);
        chk("rst_wdata", 32'(o_wdata), 32'd0);

        // Four requesters, "AB\n" each, constant req: strict 0,1,2,3 rotation.
        load(0, "AB\n"); load(1, "AB\n"); load(2, "AB\n"); load(3, "AB\n");
        en = 4'b1111; drive(); #1;
        chk("rst_hold_gnt", 32'(gnt), 32'd0);
        chk("rst_hold_busy", 32'(o_busy), 32'd0);
        tick();
        rst = 1'b0; #1;
        clear_log();
        for (int o = 0; o < 4; o++) begin
            exp_x(o, 8'h41, 2); exp_x(o, 8'h42, 1); exp_x(o, 8'h0A, 1);
        end
        run_until_done("rr", 40);
        check_log("rr");
        chk("rr_idle_busy", 32'(o_busy), 32'd0);
        chk("rr_last_owner", 32'(o_owner), 32'd3);

        // Requester 2 alone with downstream stalled for 5 cycles.
        ready = 1'b0; clear_log();
        load(2, "X\n"); en = 4'b0100; drive(); #1;
        tick();
        chk("stall_owner", 32'(o_owner), 32'd2);
        chk("stall_wreq", 32'(o_wreq), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_gnt%0d", k), 32'(gnt), 32'd0);
            chk($sformatf("stall_busy%0d", k), 32'(o_busy), 32'd1);
            chk($sformatf("stall_own%0d", k), 32'(o_owner), 32'd2);
            tick();
        end
        ready = 1'b1; #1;
        chk("resume_gnt0", 32'(gnt), 32'b0100);
        chk("resume_dat0", 32'(o_wdata), 32'h58);
        tick();
        chk("resume_gnt1", 32'(gnt), 32'b0100);
        chk("resume_dat1", 32'(o_wdata), 32'h0A);
        tick();
        chk("resume_rel", 32'(o_busy), 32'd0);
        exp_x(2, 8'h58, 1); exp_x(2, 8'h0A, 1);
        check_log("stall");

        // Requester 1 sends "Q" and drops req; timeout releases after 8 stalls.
        clear_log();
        load(1, "Q"); en = 4'b0010; drive(); #1;
        tick();
        load(3, "Z\n"); en = 4'b1010; drive(); #1;
        chk("to_owner", 32'(o_owner), 32'd1);
        chk("to_gnt", 32'(gnt), 32'b0010);
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("to_busy%0d", k), 32'(o_busy), 32'd1);
            chk($sformatf("to_gnt%0d", k), 32'(gnt), 32'd0);
            tick();
        end
        chk("to_released", 32'(o_busy), 32'd0);
        chk("to_idle_gnt", 32'(gnt), 32'd0);
        tick();
        chk("to_next_owner", 32'(o_owner), 32'd3);
        chk("to_next_gnt", 32'(gnt), 32'b1000);
        tick(); tick();
        chk("to_eom_rel", 32'(o_busy), 32'd0);
        exp_x(1, 8'h51, 1); exp_x(3, 8'h5A, 10); exp_x(3, 8'h0A, 1);
        check_log("to");

        // Burst limit of 4 interleaves requester 1 between requester 0 bursts.
        clear_log();
        load(0, "0123456789"); load(1, "R\n"); en = 4'b0011; drive(); #1;
        exp_x(0, 8'h30, 1); exp_x(0, 8'h31, 1); exp_x(0, 8'h32, 1); exp_x(0, 8'h33, 1);
        exp_x(1, 8'h52, 2); exp_x(1, 8'h0A, 1);
        exp_x(0, 8'h34, 2); exp_x(0, 8'h35, 1); exp_x(0, 8'h36, 1); exp_x(0, 8'h37, 1);
        exp_x(0, 8'h38, 2); exp_x(0, 8'h39, 1);
        run_until_done("burst", 40);
        check_log("burst");
        for (int k = 0; k < 7; k++) tick();
        chk("burst_tail_busy", 32'(o_busy), 32'd1);
        tick();
        chk("burst_tail_rel", 32'(o_busy), 32'd0);

        // Reset pulse while requester 2 is mid-message.
        load(2, "MNOP\n"); en = 4'b0100; drive(); #1;
        tick(); tick();
        chk("mid_owner", 32'(o_owner), 32'd2);
        rst = 1'b1; #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_wreq", 32'(o_wreq), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_wdata", 32'(o_wdata), 32'd0);
        tick();
        rst = 1'b0;
        load(0, "K\n"); en = 4'b0101; drive(); #1;
        clear_log();
        chk("post_rst_busy", 32'(o_busy), 32'd0);
        chk("post_rst_gnt", 32'(gnt), 32'd0);
        chk("post_rst_owner", 32'(o_owner), 32'd0);
        tick();
        chk("post_rst_grant", 32'(o_owner), 32'd0);
        chk("post_rst_gnt0", 32'(gnt), 32'b0001);
        chk("post_rst_dat", 32'(o_wdata), 32'h4B);
        exp_x(0, 8'h4B, 1); exp_x(0, 8'h0A, 1);
        exp_x(2, 8'h4E, 2); exp_x(2, 8'h4F, 1); exp_x(2, 8'h50, 1); exp_x(2, 8'h0A, 1);
        run_until_done("rstmid", 20);
        check_log("rstmid");

        // EOM lands on the 4th word of a burst: one release, rotation continues from 3.
        clear_log();
        load(0, "u\n"); load(1, "v\n"); load(3, "abc\nw\n"); en = 4'b1011; drive(); #1;
        exp_x(3, 8'h61, 1); exp_x(3, 8'h62, 1); exp_x(3, 8'h63, 1); exp_x(3, 8'h0A, 1);
        exp_x(0, 8'h75, 2); exp_x(0, 8'h0A, 1);
        exp_x(1, 8'h76, 2); exp_x(1, 8'h0A, 1);
        exp_x(3, 8'h77, 2); exp_x(3, 8'h0A, 1);
        run_until_done("eomb", 40);
        check_log("eomb");
        chk("eomb_end_busy", 32'(o_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
